// File: rtl/uart_pkg_v.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions and serializer state encoding.
package uart_pkg_v;

    // Register select values taken from DataAdr[3:2]
    localparam logic [1:0] OFS_TXDATA  = 2'd0;
    localparam logic [1:0] OFS_STATUS  = 2'd1;
    localparam logic [1:0] OFS_BAUDDIV = 2'd2;
    localparam logic [1:0] OFS_RSVD    = 2'd3;

    // STATUS register layout
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    // Smallest divider the serializer accepts
    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/fifo_sync_v.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is
// accepted when a pop happens on the same edge.
// Ports: i_clk, i_rst_n, i_push/i_wdata, i_pop, o_rdata (head),
//        o_full, o_empty, o_count (0..DEPTH).
module fifo_sync_v #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rp];

    assign w_rd = i_pop & ~o_empty;
    assign w_wr = i_push & (~o_full | w_rd);

    // Storage needs no reset: the pointers define what is valid
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wp] <= i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + AW'(1);
            if (w_rd) r_rp <= r_rp + AW'(1);
            if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
            else if (!w_wr && w_rd) r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_mmio_v.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV window.
// Ports: CLK, RESET (async, low), DataAdr/WriteData/MemWrite (bus in),
//        RdData/Sel (read path), TX (serial out), Irq (idle level).
module uart_tx_mmio_v
    import uart_pkg_v::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RST    = 16'd434
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] RdData,
    output logic        Sel,
    output logic        TX,
    output logic        Irq
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    tx_state_t     r_state;
    tx_state_t     w_next;
    logic [15:0]   r_cnt;
    logic [15:0]   r_div;
    logic [15:0]   r_baud;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_ovf;

    logic [1:0]    w_ofs;
    logic          w_we;
    logic          w_push;
    logic          w_pop;
    logic          w_tick;
    logic          w_busy;
    logic          w_tx;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_head;
    logic [31:0]   w_status;
    logic          w_unused;

    assign w_unused = ^{DataAdr[1:0], WriteData[31:16]};

    assign Sel    = (DataAdr[31:4] == BASE_ADDR[31:4]);
    assign w_ofs  = DataAdr[3:2];
    assign w_we   = MemWrite & Sel;
    assign w_push = w_we & (w_ofs == OFS_TXDATA);
    assign w_tick = (r_cnt == 16'd0);
    assign w_busy = (r_state != S_IDLE);

    fifo_sync_v #(
        .W     (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_push  (w_push),
        .i_wdata (WriteData[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_status              = '0;
        w_status[ST_FULL]     = w_full;
        w_status[ST_EMPTY]    = w_empty;
        w_status[ST_BUSY]     = w_busy;
        w_status[ST_OVF]      = r_ovf;
        w_status[ST_CNT_LSB +: 8] = 8'(w_count);
    end

    always_comb begin
        RdData = '0;
        if (Sel) begin
            case (w_ofs)
                OFS_STATUS:  RdData = w_status;
                OFS_BAUDDIV: RdData = {16'd0, r_baud};
                default:     RdData = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // A pop both leaves IDLE and chains frames out of STOP
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_tx   = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next = S_START;
                    w_pop  = 1'b1;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_tick) w_next = S_DATA;
            end
            S_DATA: begin
                w_tx = r_shift[0];
                if (w_tick && r_idx == 3'd7) w_next = S_STOP;
            end
            S_STOP: begin
                if (w_tick) begin
                    if (!w_empty) begin
                        w_next = S_START;
                        w_pop  = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
        endcase
    end

    assign TX  = w_tx;
    assign Irq = w_empty & ~w_busy;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cnt   <= '0;
            r_div   <= DIV_RST;
            r_baud  <= DIV_RST;
            r_idx   <= '0;
            r_shift <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_we && w_ofs == OFS_BAUDDIV)
                r_baud <= (WriteData[15:0] < DIV_MIN) ? DIV_MIN
                                                      : WriteData[15:0];
            if (w_we && w_ofs == OFS_STATUS && WriteData[ST_OVF])
                r_ovf <= 1'b0;
            if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
            // The divider is frozen per frame so BAUDDIV writes
            // only take effect at the next START
            if (w_pop) begin
                r_shift <= w_head;
                r_div   <= r_baud;
                r_cnt   <= r_baud - 16'd1;
                r_idx   <= '0;
            end else if (w_busy) begin
                if (w_tick) begin
                    r_cnt <= r_div - 16'd1;
                    if (r_state == S_DATA) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_idx   <= r_idx + 3'd1;
                    end
                end else begin
                    r_cnt <= r_cnt - 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio_v.sv
// Self-checking bench for uart_tx_mmio_v: TX line logged per cycle and
// compared against frames computed from the 8N1 definition.
module tb_uart_tx_mmio_v;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int LOGN = 16384;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic [31:0] RdData;
    logic        Sel;
    logic        TX;
    logic        Irq;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    bit tx_log  [LOGN];
    bit irq_log [LOGN];

    uart_tx_mmio_v dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .RdData    (RdData),
        .Sel       (Sel),
        .TX        (TX),
        .Irq       (Irq)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (cyc < LOGN) begin
            tx_log[cyc]  <= TX;
            irq_log[cyc] <= Irq;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
        $fatal(1);
    end

    // ---------------- bus and model utilities ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                             output int k);
        DataAdr   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        @(posedge CLK);
        #1;
        k = cyc;
        MemWrite = 1'b0;
        DataAdr  = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge CLK);
        DataAdr  = a;
        MemWrite = 1'b0;
        #1;
        d = RdData;
        DataAdr = '0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Line level t cycles into an 8N1 frame of byte b
    function automatic bit exp_bit(input logic [7:0] b, input int t,
                                   input int div);
        int i;
        i = t / div;
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return b[i-1];
    endfunction

    function automatic int frame_errs(input int start, input logic [7:0] b,
                                      input int div);
        int e;
        e = 0;
        for (int t = 0; t < 10 * div; t++)
            if (tx_log[start + t] !== exp_bit(b, t, div)) e++;
        return e;
    endfunction

    function automatic int idle_errs(input int start, input int len);
        int e;
        e = 0;
        for (int t = 0; t < len; t++)
            if (tx_log[start + t] !== 1'b1) e++;
        return e;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        #1 RESET = 1'b0;
        #2;
        vectors++;
        if (TX !== 1'b1 || Irq !== 1'b1) begin
            errors++;
            $display("FAIL reset_lines: TX=%b Irq=%b want 1 1", TX, Irq);
        end
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        bus_read(BASE + 32'h4, d);
        vectors++;
        if (d !== 32'h0000_0002) begin
            errors++;
            $display("FAIL reset_status: got %h want 00000002", d);
        end
        bus_read(BASE + 32'h8, d);
        vectors++;
        if (d !== 32'd434) begin
            errors++;
            $display("FAIL reset_baud: got %0d want 434", d);
        end
        bus_read(BASE + 32'h0, d);
        vectors++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL txdata_read: got %h want 0", d);
        end
        bus_read(BASE + 32'hC, d);
        vectors++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL rsvd_read: got %h want 0", d);
        end
        @(negedge CLK);
        DataAdr = BASE + 32'h7;
        #1;
        vectors++;
        if (Sel !== 1'b1 || RdData !== 32'h0000_0002) begin
            errors++;
            $display("FAIL sel_in: Sel=%b RdData=%h want 1 00000002",
                     Sel, RdData);
        end
        DataAdr = BASE + 32'h14;
        #1;
        vectors++;
        if (Sel !== 1'b0 || RdData !== 32'h0) begin
            errors++;
            $display("FAIL sel_out: Sel=%b RdData=%h want 0 0", Sel, RdData);
        end
        DataAdr = '0;
        vectors++;
        if (tx_log[cyc - 1] !== 1'b1 || irq_log[cyc - 1] !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_log: TX=%b Irq=%b want 1 1",
                     tx_log[cyc - 1], irq_log[cyc - 1]);
        end
    endtask

    task automatic test_single();
        int k, kd, div, e;
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b   = (i == 0) ? 8'hA5 : 8'($urandom);
            div = (i == 0) ? 4 : int'($urandom_range(2, 6));
            bus_write(BASE + 32'h8, div, kd);
            bus_write(BASE + 32'h0, {24'd0, b}, k);
            wait_cycles(10 * div + 4);
            e = frame_errs(k + 1, b, div);
            vectors++;
            if (e !== 0) begin
                errors++;
                $display("FAIL single_frame: byte %h div %0d bad cycles %0d want 0",
                         b, div, e);
            end
            vectors++;
            if (tx_log[k] !== 1'b1 || irq_log[k + 10 * div] !== 1'b0
                || irq_log[k + 10 * div + 1] !== 1'b1
                || tx_log[k + 10 * div + 1] !== 1'b1) begin
                errors++;
                $display("FAIL single_edges: tx@k=%b irq_end=%b irq_after=%b want 1 0 1",
                         tx_log[k], irq_log[k + 10 * div],
                         irq_log[k + 10 * div + 1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int k[9];
        int kd, e;
        logic [31:0] d;
        bus_write(BASE + 32'h8, 32'd4, kd);
        for (int i = 0; i < 9; i++)
            bus_write(BASE + 32'h0, i, k[i]);
        bus_read(BASE + 32'h4, d);
        vectors++;
        if (d[3] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_ovf: status %h want overflow 0", d);
        end
        wait_cycles(9 * 40 + 5);
        e = 0;
        for (int i = 0; i < 9; i++)
            e += frame_errs(k[0] + 1 + 40 * i, 8'(i), 4);
        vectors++;
        if (e !== 0) begin
            errors++;
            $display("FAIL b2b_frames: bad cycles %0d want 0", e);
        end
        vectors++;
        if (irq_log[k[0] + 360] !== 1'b0 || irq_log[k[0] + 361] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_irq: irq %b%b want 01",
                     irq_log[k[0] + 360], irq_log[k[0] + 361]);
        end
        bus_read(BASE + 32'h4, d);
        vectors++;
        if (d !== 32'h0000_0002) begin
            errors++;
            $display("FAIL b2b_status: got %h want 00000002", d);
        end
    endtask

    task automatic test_overflow();
        int k0, kd, kx, e;
        logic [7:0] b0;
        logic [7:0] q[$];
        logic [7:0] b;
        logic [31:0] d;
        bus_write(BASE + 32'h8, 32'd4, kd);
        b0 = 8'($urandom);
        bus_write(BASE + 32'h0, {24'd0, b0}, k0);
        // serializer has popped b0; fill an empty FIFO of depth 8
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            if (q.size() < 8) q.push_back(b);
            bus_write(BASE + 32'h0, {24'd0, b}, kx);
        end
        bus_read(BASE + 32'h4, d);
        vectors++;
        if (d !== 32'h0000_080D) begin
            errors++;
            $display("FAIL ovf_status: got %h want 0000080D", d);
        end
        bus_write(BASE + 32'h4, 32'h8, kx);
        bus_read(BASE + 32'h4, d);
        vectors++;
        if (d !== 32'h0000_0805) begin
            errors++;
            $display("FAIL ovf_clear: got %h want 00000805", d);
        end
        wait_cycles(9 * 40 + 45);
        e = frame_errs(k0 + 1, b0, 4);
        for (int i = 0; i < 8; i++)
            e += frame_errs(k0 + 1 + 40 * (i + 1), q[i], 4);
        vectors++;
        if (e !== 0) begin
            errors++;
            $display("FAIL ovf_frames: bad cycles %0d want 0", e);
        end
        e = idle_errs(k0 + 361, 40);
        vectors++;
        if (e !== 0) begin
            errors++;
            $display("FAIL ovf_dropped: extra frame, bad cycles %0d want 0", e);
        end
    endtask

    task automatic test_baud_change();
        int k, kd, k2, e;
        logic [31:0] d;
        logic [15:0] v;
        bus_write(BASE + 32'h8, 32'd4, kd);
        bus_write(BASE + 32'h0, 32'h55, k);
        wait_cycles(10);
        bus_write(BASE + 32'h8, 32'd8, kd);
        bus_write(BASE + 32'h0, 32'h55, k2);
        wait_cycles(130);
        e = frame_errs(k + 1, 8'h55, 4);
        vectors++;
        if (e !== 0) begin
            errors++;
            $display("FAIL baud_frame1: bad cycles %0d want 0", e);
        end
        e = frame_errs(k + 41, 8'h55, 8);
        vectors++;
        if (e !== 0) begin
            errors++;
            $display("FAIL baud_frame2: bad cycles %0d want 0", e);
        end
        vectors++;
        if (tx_log[k + 121] !== 1'b1 || irq_log[k + 121] !== 1'b1
            || irq_log[k + 120] !== 1'b0) begin
            errors++;
            $display("FAIL baud_end: irq %b%b want 01",
                     irq_log[k + 120], irq_log[k + 121]);
        end
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: v = 16'd1;
                1: v = 16'd0;
                2: v = 16'($urandom_range(2, 65535));
                default: v = 16'd3;
            endcase
            bus_write(BASE + 32'h8, {16'hFFFF, v}, kd);
            bus_read(BASE + 32'h8, d);
            vectors++;
            if (d !== {16'd0, (v < 16'd2) ? 16'd2 : v}) begin
                errors++;
                $display("FAIL baud_rw: wrote %0d got %0d", v, d);
            end
        end
    endtask

    task automatic test_random();
        int div, n, k0, kx, e;
        logic [7:0] q[$];
        for (int it = 0; it < 4; it++) begin
            q.delete();
            div = int'($urandom_range(2, 5));
            n   = int'($urandom_range(1, 8));
            bus_write(BASE + 32'h8, div, kx);
            for (int i = 0; i < n; i++) begin
                q.push_back(8'($urandom));
                bus_write(BASE + 32'h0, {24'd0, q[i]}, kx);
                if (i == 0) k0 = kx;
            end
            // stores outside the window or to the reserved slot
            bus_write(BASE + 32'h10, $urandom, kx);
            bus_write(BASE + 32'hC, $urandom, kx);
            bus_write(32'h0000_0000, $urandom, kx);
            wait_cycles(n * 10 * div + 25);
            e = 0;
            for (int i = 0; i < n; i++)
                e += frame_errs(k0 + 1 + i * 10 * div, q[i], div);
            vectors++;
            if (e !== 0) begin
                errors++;
                $display("FAIL rand_frames: n %0d div %0d bad cycles %0d want 0",
                         n, div, e);
            end
            e = idle_errs(k0 + 1 + n * 10 * div, 20);
            vectors++;
            if (e !== 0 || irq_log[k0 + 1 + n * 10 * div] !== 1'b1) begin
                errors++;
                $display("FAIL rand_idle: bad cycles %0d irq %b want 0 1",
                         e, irq_log[k0 + 1 + n * 10 * div]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k, kx, rel, e;
        logic [7:0] b;
        logic [31:0] d;
        bus_write(BASE + 32'h8, 32'd4, kx);
        b = 8'($urandom) & 8'hFB;
        bus_write(BASE + 32'h0, {24'd0, b}, k);
        bus_write(BASE + 32'h0, $urandom, kx);
        wait_cycles(14);
        #2;
        vectors++;
        if (TX !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_pre: TX=%b want 0", TX);
        end
        RESET = 1'b0;
        #1;
        vectors++;
        if (TX !== 1'b1 || Irq !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_async: TX=%b Irq=%b want 1 1", TX, Irq);
        end
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        rel = cyc;
        bus_read(BASE + 32'h4, d);
        vectors++;
        if (d !== 32'h0000_0002) begin
            errors++;
            $display("FAIL rstmid_status: got %h want 00000002", d);
        end
        bus_read(BASE + 32'h8, d);
        vectors++;
        if (d !== 32'd434) begin
            errors++;
            $display("FAIL rstmid_baud: got %0d want 434", d);
        end
        wait_cycles(60);
        e = idle_errs(rel, 55);
        vectors++;
        if (e !== 0) begin
            errors++;
            $display("FAIL rstmid_residual: bad cycles %0d want 0", e);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_baud_change();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio_v.md
Name: uart_tx_mmio_v

Overview:
Memory-mapped UART transmitter on the core's data bus, downstream of the processor top level. It consumes the DataAdr, WriteData and MemWrite outputs in parallel with data RAM. Stores to its address window push bytes into a small FIFO, which a serializer drains as 8N1 frames on TX. Loads from its window return status and divider registers through a combinational read path.

Parameters:
BASE_ADDR, 32'h0000_1000, byte address of register window (16-byte aligned)
FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64
DIV_RST, 434, reset value of BAUDDIV (bit period in CLK cycles)

Ports:
CLK  in  1  system clock, rising-edge
RESET  in  1  asynchronous, active-low reset
DataAdr  in  32  core data address (ALU result)
WriteData  in  32  core store data
MemWrite  in  1  core store strobe, one cycle per store
RdData  out  32  combinational register read data; 0 outside window
Sel  out  1  DataAdr inside window (for read-data mux select)
TX  out  1  serial output, idle high
Irq  out  1  level, high while FIFO empty and serializer idle

Behaviour:
- One clock; reset is asynchronous and active-low.
- Window decode: Sel = (DataAdr[31:4] == BASE_ADDR[31:4]); DataAdr[3:2] selects the register; DataAdr[1:0] are ignored.
- Register map:
  - 0x0 TXDATA: a write pushes WriteData[7:0]; reads return 0.
  - 0x4 STATUS, read: bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky), bits[15:8] count. A write with WriteData[3]=1 clears overflow.
  - 0x8 BAUDDIV: read/write, 16 bits. A written value <2 is stored as 2.
  - 0xC: reserved; reads return 0 and writes are ignored.
- Reset values:
  - TX=1, Irq=1.
  - FIFO empty, count=0, overflow=0.
  - BAUDDIV=DIV_RST, FSM=IDLE.
  - RdData follows decode and is 0 when Sel=0.
- Push: occurs on a CLK edge with MemWrite=1, Sel=1 and offset 0x0.
  - Accepted if count<FIFO_DEPTH, or if a pop occurs on the same edge.
  - Otherwise the byte is dropped and overflow is set.
- Pop: occurs on the IDLE->START transition. The byte is latched into the shift register, and BAUDDIV is snapshotted into the frame divider.
- FSM states:
  - IDLE: TX=1. Moves to START on the first edge where the FIFO is non-empty. A byte pushed at edge k leaves IDLE at edge k+1, so TX falls after edge k+1.
  - START: TX=0 for div cycles, then DATA.
  - DATA: 8 bits, LSB first, div cycles each. A 3-bit index counts 0..7; after bit 7, go to STOP.
  - STOP: TX=1 for div cycles. Then go to START if the FIFO is non-empty (back-to-back, no idle gap), else IDLE.
- Bit timing: a 16-bit counter runs from div-1 down to 0. A bit/state advance happens on the edge where the counter is 0. Frame length is 10*div cycles.
- busy=1 in every state except IDLE. Irq = empty & ~busy.
- A BAUDDIV write mid-frame does not affect the current frame; it applies from the next START.
- Count is always 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-frame: TX goes to 1 immediately (asynchronous) and the FIFO contents are discarded.
- Non-window stores are ignored. The block never stalls the core.

Decomposition:
- Shared package uart_pkg_v:
  - register offsets (OFS_TXDATA/STATUS/BAUDDIV)
  - STATUS bit positions
  - FSM state encoding (IDLE, START, DATA, STOP; 2-bit)
- Sub-module fifo_sync_v (parameterised width and depth):
  - push/pop/full/empty/count, with same-edge push+pop when full permitted
  - top block holds decode, registers, FSM and baud counter

Test Plan:
- Reset then read STATUS -> RdData=32'h0000_0002 (empty=1); read BAUDDIV -> 434; TX=1; Irq=1.
- BAUDDIV=4, write 0xA5 to TXDATA -> TX: 4 cycles 0, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 4 cycles 1; busy for 40 cycles; Irq returns to 1 on the following cycle.
- BAUDDIV=4, nine consecutive TXDATA writes 0x00..0x08 -> first byte pops one edge after its write, so all nine are accepted with no overflow. Output is nine contiguous 40-cycle frames with no idle gap between them.
- BAUDDIV=4, hold serializer busy, write 9 bytes into empty FIFO with no pop -> 9th dropped; STATUS=0x0000_080D (count 8, full, busy, overflow). Writing STATUS with 0x8 clears overflow.
- BAUDDIV=4, write 0x55, write BAUDDIV=8 during DATA, then write 0x55 -> first frame 40 cycles, second frame 80 cycles; write BAUDDIV=1 reads back 2.
- Assert RESET (low) mid-DATA -> TX=1 in the same cycle; after release STATUS shows empty and not busy, and no residual frame is sent.
